// File: rtl/aes_key_sched_iter.sv
// ---------------------------------------------------------------------------
// aes_key_sched_iter
//
// Iterative AES key-schedule engine for AES-128 or AES-256 (KEY_BITS).
// It streams the NR+1 round keys as 128-bit words {w0,w1,w2,w3} over a
// valid/ready handshake. One shared 32-bit S-box stage (aes_s4) with a
// registered input is used for every round.
//
// Ports:
//   clk       input   1    clock
//   reset     input   1    asynchronous reset, active low
//   start     input   1    begin a schedule (sampled only while idle)
//   abort     input   1    synchronous cancel of the running schedule
//   key_in    input   256  cipher key; AES-128 uses key_in[255:128]
//   busy      output  1    schedule in progress
//   rk_valid  output  1    rk_data holds a round key
//   rk_ready  input   1    consumer accepts the round key
//   rk_data   output  128  round key {w0,w1,w2,w3}
//   rk_idx    output  4    round index of rk_data, 0..NR
//   done      output  1    one-cycle pulse after round key NR is accepted
//
// Optional build macro KEY_SCHED_ZEROIZE_EN: when defined, the key window,
// rk_data register and S-box input register are cleared on the edge that
// returns to IDLE after done or abort, and rk_data reads 0 while
// rk_valid is low.
// ---------------------------------------------------------------------------

// Four parallel AES S-boxes behind one 32-bit input register, so the
// substituted word is available one cycle after it is loaded.
module aes_s4 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ld_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);
    logic [31:0] in_q;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // S-box computed as x^254 (the field inverse, with 0 -> 0) followed by
    // the AES affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pw  = gfMul(pw, pw);
            inv = gfMul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_q <= '0;
        end else if (ld_i) begin
            in_q <= d_i;
        end
    end

    assign q_o = {sbox(in_q[31:24]), sbox(in_q[23:16]), sbox(in_q[15:8]), sbox(in_q[7:0])};
endmodule

module aes_key_sched_iter #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         done
);
    localparam int          NR     = (KEY_BITS == 128) ? 10 : 14;
    localparam logic [3:0]  NR_IDX = 4'(NR);
    localparam int          NK     = KEY_BITS / 32;
    // Bit offset of the newest key word inside the 256-bit window.
    localparam int          LAST_LSB = 256 - 32 * NK;

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : gKeyBitsCheck
            $error("aes_key_sched_iter: KEY_BITS must be 128 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EMIT, SUB, CALC} state_e;

    state_e         state_q, state_d;
    logic [255:0]   win_q, win_d;
    logic [127:0]   rk_data_q, rk_data_d;
    logic [3:0]     rk_idx_q, rk_idx_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           done_q, done_d;

    logic [31:0]    lastWord, s4In, s4Din, s4Out, temp;
    logic [31:0]    n0, n1, n2, n3;
    logic           rotSel, s4Ld;

    // AES-256 alternates: steps producing an even round index use
    // RotWord+Rcon, odd ones only SubWord. During SUB/CALC rk_idx_q still
    // holds the previous index, so "next is even" means rk_idx_q is odd.
    assign rotSel   = (KEY_BITS == 128) || rk_idx_q[0];
    assign lastWord = win_q[LAST_LSB +: 32];
    assign s4In     = rotSel ? {lastWord[23:0], lastWord[31:24]} : lastWord;

    assign temp = s4Out ^ (rotSel ? {rcon_q, 24'h0} : 32'h0);
    assign n0   = win_q[255:224] ^ temp;
    assign n1   = win_q[223:192] ^ n0;
    assign n2   = win_q[191:160] ^ n1;
    assign n3   = win_q[159:128] ^ n2;

`ifdef KEY_SCHED_ZEROIZE_EN
    logic leaving;
    assign leaving = (state_q != IDLE) && (state_d == IDLE);
    assign s4Ld    = (state_q == SUB) || leaving;
    assign s4Din   = leaving ? 32'h0 : s4In;
`else
    assign s4Ld    = (state_q == SUB);
    assign s4Din   = s4In;
`endif

    // The S-box stage keeps its reset inactive; its output only matters in CALC.
    aes_s4 u_s4 (
        .clk_i  (clk),
        .rst_ni (1'b1),
        .ld_i   (s4Ld),
        .d_i    (s4Din),
        .q_o    (s4Out)
    );

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        rk_data_d = rk_data_q;
        rk_idx_d  = rk_idx_q;
        rcon_d    = rcon_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d     = (KEY_BITS == 128) ? {key_in[255:128], 128'h0} : key_in;
                    rk_data_d = key_in[255:128];
                    rk_idx_d  = 4'd0;
                    rcon_d    = 8'h01;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (rk_idx_q == NR_IDX) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (KEY_BITS == 256 && rk_idx_q == 4'd0) begin
                        // The second half of an AES-256 key is round key 1 as-is.
                        rk_data_d = win_q[127:0];
                        rk_idx_d  = 4'd1;
                    end else begin
                        state_d = SUB;
                    end
                end
            end
            SUB: begin
                state_d = CALC;
            end
            CALC: begin
                if (KEY_BITS == 128) begin
                    win_d = {n0, n1, n2, n3, 128'h0};
                end else begin
                    win_d = {win_q[127:0], n0, n1, n2, n3};
                end
                rk_data_d = {n0, n1, n2, n3};
                rk_idx_d  = rk_idx_q + 4'd1;
                if (rotSel) begin
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
                state_d = EMIT;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything while busy, including a handshake on
        // the same edge; in IDLE a simultaneous start takes priority.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            rk_idx_d = 4'd0;
        end

`ifdef KEY_SCHED_ZEROIZE_EN
        if (state_q != IDLE && state_d == IDLE) begin
            win_d     = '0;
            rk_data_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            win_q     <= '0;
            rk_data_q <= '0;
            rk_idx_q  <= 4'd0;
            rcon_q    <= 8'h01;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            rk_data_q <= rk_data_d;
            rk_idx_q  <= rk_idx_d;
            rcon_q    <= rcon_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = (state_q == EMIT);
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;
`ifdef KEY_SCHED_ZEROIZE_EN
    assign rk_data  = rk_valid ? rk_data_q : 128'h0;
`else
    assign rk_data  = rk_data_q;
`endif
endmodule

// File: tb/tb_aes_key_sched_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_iter
//
// Directed bench for aes_key_sched_iter with one AES-128 and one AES-256
// instance sharing clock and reset. Expected round keys are the FIPS-197
// key-expansion vectors for the sequential test keys.
// Honours KEY_SCHED_ZEROIZE_EN for the post-done rk_data expectation.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstN;

    logic         start128, abort128, ready128;
    logic [255:0] key128;
    logic         busy128, valid128, done128;
    logic [127:0] data128;
    logic [3:0]   idx128;

    logic         start256, abort256, ready256;
    logic [255:0] key256;
    logic         busy256, valid256, done256;
    logic [127:0] data256;
    logic [3:0]   idx256;

    int errors = 0;
    int checks = 0;

    logic [127:0] exp128 [11];

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_sched_iter #(.KEY_BITS(128)) dut128 (
        .clk(clk), .reset(rstN), .start(start128), .abort(abort128),
        .key_in(key128), .busy(busy128), .rk_valid(valid128),
        .rk_ready(ready128), .rk_data(data128), .rk_idx(idx128), .done(done128)
    );

    aes_key_sched_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .reset(rstN), .start(start256), .abort(abort256),
        .key_in(key256), .busy(busy256), .rk_valid(valid256),
        .rk_ready(ready256), .rk_data(data256), .rk_idx(idx256), .done(done256)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        start128 = 0; abort128 = 0; ready128 = 0; key128 = '0;
        start256 = 0; abort256 = 0; ready256 = 0; key256 = '0;
        #2 rstN = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy128, valid128, done128, idx128, data128} !== '0) begin
            errors++;
            $display("[TB] FAIL reset128: got busy=%b valid=%b done=%b idx=%0d data=%h, want all 0",
                     busy128, valid128, done128, idx128, data128);
        end
        checks++;
        if ({busy256, valid256, done256, idx256, data256} !== '0) begin
            errors++;
            $display("[TB] FAIL reset256: got busy=%b valid=%b done=%b idx=%0d data=%h, want all 0",
                     busy256, valid256, done256, idx256, data256);
        end
        rstN = 1'b1;
        tick();
    endtask

    // Full AES-128 schedule; readyPct is the chance (in %) that rk_ready is
    // high on a valid cycle. Every valid cycle, held or fresh, must show the
    // expected key for the current index.
    task automatic test_schedule128(input int readyPct, input string tag);
        int cyc;
        int n;
        int doneCyc;
        bit doneSeen;
        logic [127:0] wantAfter;
        key128 = {KEY_A, 128'h0};
        ready128 = 0;
        start128 = 1;
        tick();
        start128 = 0;
        cyc = 0; n = 0; doneSeen = 0; doneCyc = -1;
        while (!doneSeen && cyc < 400) begin
            if (done128) begin
                doneSeen = 1;
                doneCyc = cyc;
            end else begin
                if (valid128) begin
                    checks++;
                    if (n > 10) begin
                        errors++;
                        $display("[TB] FAIL %s extra key: got idx=%0d, want none after idx 10", tag, idx128);
                    end else if (data128 !== exp128[n] || idx128 !== 4'(n)) begin
                        errors++;
                        $display("[TB] FAIL %s key: got idx=%0d data=%h, want idx=%0d data=%h",
                                 tag, idx128, data128, n, exp128[n]);
                    end
                    ready128 = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
                    if (ready128) n++;
                end else begin
                    ready128 = 0;
                end
            end
            if (!doneSeen) begin
                tick();
                cyc++;
            end
        end
        checks++;
        if (!doneSeen || n != 11) begin
            errors++;
            $display("[TB] FAIL %s completion: got done=%b keys=%0d, want done=1 keys=11", tag, doneSeen, n);
        end
        if (readyPct >= 100) begin
            checks++;
            if (doneCyc != 31) begin
                errors++;
                $display("[TB] FAIL %s latency: got %0d cycles, want 31", tag, doneCyc);
            end
        end
        checks++;
        if (busy128 !== 1'b0 || valid128 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got busy=%b valid=%b, want 0 0", tag, busy128, valid128);
        end
`ifdef KEY_SCHED_ZEROIZE_EN
        wantAfter = 128'h0;
`else
        wantAfter = exp128[10];
`endif
        checks++;
        if (data128 !== wantAfter) begin
            errors++;
            $display("[TB] FAIL %s data_after_done: got %h, want %h", tag, data128, wantAfter);
        end
        ready128 = 0;
        tick();
        checks++;
        if (done128 !== 1'b0 || data128 !== wantAfter) begin
            errors++;
            $display("[TB] FAIL %s done_pulse: got done=%b data=%h, want done=0 data=%h",
                     tag, done128, data128, wantAfter);
        end
    endtask

    task automatic test_aes256();
        int cyc;
        int n;
        int doneCyc;
        int donePulses;
        logic [127:0] want;
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ready256 = 1;
        start256 = 1;
        tick();
        start256 = 0;
        cyc = 0; n = 0; doneCyc = -1; donePulses = 0;
        while (cyc < 60) begin
            if (done256) begin
                donePulses++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (valid256) begin
                checks++;
                if (idx256 !== 4'(n)) begin
                    errors++;
                    $display("[TB] FAIL aes256 idx: got %0d, want %0d", idx256, n);
                end
                want = 'x;
                case (n)
                    0:  want = 128'h000102030405060708090a0b0c0d0e0f;
                    1:  want = 128'h101112131415161718191a1b1c1d1e1f;
                    2:  want = 128'ha573c29fa176c498a97fce93a572c09c;
                    14: want = 128'h24fc79ccbf0979e9371ac23c6d68de36;
                    default: ;
                endcase
                if (n == 0 || n == 1 || n == 2 || n == 14) begin
                    checks++;
                    if (data256 !== want) begin
                        errors++;
                        $display("[TB] FAIL aes256 rk%0d: got %h, want %h", n, data256, want);
                    end
                end
                n++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (n != 15 || donePulses != 1 || doneCyc != 41) begin
            errors++;
            $display("[TB] FAIL aes256 summary: got keys=%0d done_pulses=%0d done_cycle=%0d, want 15 1 41",
                     n, donePulses, doneCyc);
        end
        ready256 = 0;
    endtask

    task automatic test_abort();
        int cyc;
        key128 = {KEY_A, 128'h0};
        ready128 = 1;
        start128 = 1;
        tick();
        start128 = 0;
        cyc = 0;
        while (!(valid128 === 1'b1 && idx128 === 4'd3) && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 50) begin
            errors++;
            $display("[TB] FAIL abort wait_rk3: got timeout after %0d cycles, want rk3 valid", cyc);
        end
        tick();
        tick();
        checks++;
        if (busy128 !== 1'b1 || valid128 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort in_calc: got busy=%b valid=%b, want 1 0", busy128, valid128);
        end
        abort128 = 1;
        tick();
        abort128 = 0;
        checks++;
        if (busy128 !== 1'b0 || valid128 !== 1'b0 || done128 !== 1'b0 || idx128 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL abort result: got busy=%b valid=%b done=%b idx=%0d, want 0 0 0 0",
                     busy128, valid128, done128, idx128);
        end
        // Immediate restart with start and abort together: start must win.
        key128 = {KEY_B, 128'h0};
        ready128 = 0;
        start128 = 1;
        abort128 = 1;
        tick();
        start128 = 0;
        abort128 = 0;
        checks++;
        if (valid128 !== 1'b1 || busy128 !== 1'b1 || done128 !== 1'b0 || idx128 !== 4'd0 || data128 !== KEY_B) begin
            errors++;
            $display("[TB] FAIL abort restart: got valid=%b busy=%b done=%b idx=%0d data=%h, want 1 1 0 0 %h",
                     valid128, busy128, done128, idx128, data128, KEY_B);
        end
        // Abort on the same edge as a handshake.
        ready128 = 1;
        abort128 = 1;
        tick();
        abort128 = 0;
        ready128 = 0;
        checks++;
        if (busy128 !== 1'b0 || valid128 !== 1'b0 || done128 !== 1'b0 || idx128 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL abort handshake: got busy=%b valid=%b done=%b idx=%0d, want 0 0 0 0",
                     busy128, valid128, done128, idx128);
        end
        tick();
        checks++;
        if (done128 !== 1'b0 || busy128 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort no_done: got done=%b busy=%b, want 0 0", done128, busy128);
        end
    endtask

    task automatic test_start_busy_reset();
        key128 = {KEY_A, 128'h0};
        ready128 = 0;
        start128 = 1;
        tick();
        start128 = 0;
        key128 = {KEY_B, 128'h0};
        start128 = 1;
        tick();
        start128 = 0;
        checks++;
        if (valid128 !== 1'b1 || busy128 !== 1'b1 || idx128 !== 4'd0 || data128 !== KEY_A) begin
            errors++;
            $display("[TB] FAIL start_busy rk0: got valid=%b busy=%b idx=%0d data=%h, want 1 1 0 %h",
                     valid128, busy128, idx128, data128, KEY_A);
        end
        ready128 = 1;
        tick();
        ready128 = 0;
        tick();
        tick();
        checks++;
        if (valid128 !== 1'b1 || idx128 !== 4'd1 || data128 !== exp128[1]) begin
            errors++;
            $display("[TB] FAIL start_busy rk1: got valid=%b idx=%0d data=%h, want 1 1 %h",
                     valid128, idx128, data128, exp128[1]);
        end
        // Assert reset between clock edges while rk1 is being offered.
        #3 rstN = 1'b0;
        #1;
        checks++;
        if ({busy128, valid128, done128, idx128, data128} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b valid=%b done=%b idx=%0d data=%h, want all 0",
                     busy128, valid128, done128, idx128, data128);
        end
        #1 rstN = 1'b1;
        tick();
        tick();
        checks++;
        if (valid128 !== 1'b0 || busy128 !== 1'b0 || idx128 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_restart: got valid=%b busy=%b idx=%0d, want 0 0 0",
                     valid128, busy128, idx128);
        end
    endtask

    initial begin
        exp128[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        exp128[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        exp128[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        exp128[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        exp128[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        exp128[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        exp128[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        exp128[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        exp128[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        exp128[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        exp128[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        test_reset();
        test_schedule128(100, "sched128");
        test_schedule128(30, "backpressure");
        test_aes256();
        test_abort();
        test_start_busy_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
